// File: rtl/cmp_feeder_if.sv
// cmp_feeder_if -- groups the load, control and comparator-facing signals of cmp_feeder.
// master: the feeder itself. slave: the environment (loader, controller and comparator).
interface cmp_feeder_if;
  // Bitmap loading
  logic        load_valid;
  logic [23:0] load_row;
  logic        load_ready;
  // Feed control
  logic        go;
  logic        busy;
  logic        cmp_start;
  // Data slices towards the comparator
  logic [63:0] bitcolumn;
  logic [23:0] bitrowtop;
  logic [23:0] bitrowbot;
  logic        nextcolumnready;
  logic        nextrowtopready;
  logic        nextrowbotready;
  logic        lastcolumn;
  // Comparator feedback
  logic        nextcolumn;
  logic        nextrowtop;
  logic        nextrowbot;
  logic        cmp_done;
  logic [15:0] cmp_result;
  // Outcome
  logic [15:0] result;
  logic        result_valid;
  logic        timeout_err;

  modport master (
    input  load_valid, load_row, go, nextcolumn, nextrowtop, nextrowbot, cmp_done, cmp_result,
    output load_ready, busy, cmp_start, bitcolumn, bitrowtop, bitrowbot,
           nextcolumnready, nextrowtopready, nextrowbotready, lastcolumn,
           result, result_valid, timeout_err
  );

  modport slave (
    output load_valid, load_row, go, nextcolumn, nextrowtop, nextrowbot, cmp_done, cmp_result,
    input  load_ready, busy, cmp_start, bitcolumn, bitrowtop, bitrowbot,
           nextcolumnready, nextrowtopready, nextrowbotready, lastcolumn,
           result, result_valid, timeout_err
  );
endinterface

// File: rtl/cmp_feeder.sv
// cmp_feeder -- holds a 64x24 bitmap and streams it to a slice comparator over three
// independent channels: columns (0..23), rows from the top (0..63) and rows from the
// bottom (63..0). Each channel sends a slice, then waits for the comparator's request
// level to drop and rise again before sending the next one.
// Optional watchdog: define CMP_FEEDER_TIMEOUT_EN to abort a stalled feed.
module cmp_feeder (
  input  logic         clk,
  input  logic         rst_n,
  cmp_feeder_if.master bus
);

  typedef enum logic [1:0] {IDLE, START, FEED} top_e;
  typedef enum logic [2:0] {CH_IDLE, CH_SEND, CH_WAITLOW, CH_WAITHIGH, CH_DONE} ch_e;

  logic [23:0] mem_q [64];

  top_e        state_q, state_d;
  logic [5:0]  wptr_q, wptr_d;
  logic        loaded_q, loaded_d;
  ch_e         colst_q, colst_d, topst_q, topst_d, botst_q, botst_d;
  logic [4:0]  col_q, col_d;
  logic [5:0]  top_q, top_d, bot_q, bot_d;
  logic [63:0] bitcol_q, bitcol_d;
  logic [23:0] bittop_q, bittop_d, bitbot_q, bitbot_d;
  logic        rdyc_q, rdyc_d, rdyt_q, rdyt_d, rdyb_q, rdyb_d;
  logic        last_q, last_d;
  logic [15:0] result_q, result_d;
  logic        rv_q, rv_d;
`ifdef CMP_FEEDER_TIMEOUT_EN
  logic [7:0]  wd_q, wd_d;
  logic        tmo_q, tmo_d;
`endif

  // Channel sequencing shared by all three channels.
  function automatic ch_e ch_step(input ch_e st, input logic req, input logic final_idx);
    ch_e nxt;
    nxt = st;
    case (st)
      CH_SEND:     nxt = CH_WAITLOW;
      CH_WAITLOW:  if (!req) nxt = CH_WAITHIGH;
      CH_WAITHIGH: if (req) nxt = final_idx ? CH_DONE : CH_SEND;
      default:     nxt = st;
    endcase
    return nxt;
  endfunction

  // True when a channel moves on to its next slice index.
  function automatic logic ch_adv(input ch_e st, input logic req, input logic final_idx);
    return (st == CH_WAITHIGH) && req && !final_idx;
  endfunction

  // Bitmap storage: rows are only written while idle, so reads during a feed are stable.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && bus.load_valid) mem_q[wptr_q] <= bus.load_row;
  end

  // Next-state logic for the top FSM, the channel FSMs and the registered outputs.
  always_comb begin
    state_d  = state_q;
    wptr_d   = wptr_q;
    loaded_d = loaded_q;
    colst_d  = colst_q;
    topst_d  = topst_q;
    botst_d  = botst_q;
    col_d    = col_q;
    top_d    = top_q;
    bot_d    = bot_q;
    bitcol_d = bitcol_q;
    bittop_d = bittop_q;
    bitbot_d = bitbot_q;
    last_d   = last_q;
    result_d = result_q;
    rv_d     = 1'b0;
`ifdef CMP_FEEDER_TIMEOUT_EN
    wd_d     = wd_q;
    tmo_d    = tmo_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.load_valid) begin
          wptr_d = wptr_q + 6'd1;
          if (wptr_q == 6'd63) loaded_d = 1'b1;
        end
        // go sees the loaded flag as it was before any write in this same cycle
        if (bus.go && loaded_q) state_d = START;
      end
      START: begin
        state_d = FEED;
        col_d   = 5'd0;
        top_d   = 6'd0;
        bot_d   = 6'd63;
        last_d  = 1'b0;
        colst_d = CH_SEND;
        topst_d = CH_SEND;
        botst_d = CH_SEND;
`ifdef CMP_FEEDER_TIMEOUT_EN
        wd_d    = 8'd0;
        tmo_d   = 1'b0;
`endif
      end
      FEED: begin
        colst_d = ch_step(colst_q, bus.nextcolumn, col_q == 5'd23);
        topst_d = ch_step(topst_q, bus.nextrowtop, top_q == 6'd63);
        botst_d = ch_step(botst_q, bus.nextrowbot, bot_q == 6'd0);
        if (ch_adv(colst_q, bus.nextcolumn, col_q == 5'd23)) col_d = col_q + 5'd1;
        if (ch_adv(topst_q, bus.nextrowtop, top_q == 6'd63)) top_d = top_q + 6'd1;
        if (ch_adv(botst_q, bus.nextrowbot, bot_q == 6'd0))  bot_d = bot_q - 6'd1;
`ifdef CMP_FEEDER_TIMEOUT_EN
        // any slice handed out counts as progress
        if (rdyc_q || rdyt_q || rdyb_q) wd_d = 8'd0;
        else                             wd_d = wd_q + 8'd1;
        if (!bus.cmp_done && wd_d == 8'hFF) begin
          tmo_d   = 1'b1;
          state_d = IDLE;
          colst_d = CH_IDLE;
          topst_d = CH_IDLE;
          botst_d = CH_IDLE;
        end
`endif
        // the comparator's verdict ends the feed whatever the channels are doing
        if (bus.cmp_done) begin
          result_d = bus.cmp_result;
          rv_d     = 1'b1;
          state_d  = IDLE;
          colst_d  = CH_IDLE;
          topst_d  = CH_IDLE;
          botst_d  = CH_IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Slice data and its ready pulse are registered together on entry to SEND.
    rdyc_d = (colst_d == CH_SEND);
    rdyt_d = (topst_d == CH_SEND);
    rdyb_d = (botst_d == CH_SEND);
    if (rdyc_d) begin
      for (int r = 0; r < 64; r++) bitcol_d[r] = mem_q[r][col_d];
      if (col_d == 5'd23) last_d = 1'b1;
    end
    if (rdyt_d) bittop_d = mem_q[top_d];
    if (rdyb_d) bitbot_d = mem_q[bot_d];
  end

  // State and output registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wptr_q   <= 6'd0;
      loaded_q <= 1'b0;
      colst_q  <= CH_IDLE;
      topst_q  <= CH_IDLE;
      botst_q  <= CH_IDLE;
      col_q    <= 5'd0;
      top_q    <= 6'd0;
      bot_q    <= 6'd63;
      bitcol_q <= '0;
      bittop_q <= '0;
      bitbot_q <= '0;
      rdyc_q   <= 1'b0;
      rdyt_q   <= 1'b0;
      rdyb_q   <= 1'b0;
      last_q   <= 1'b0;
      result_q <= '0;
      rv_q     <= 1'b0;
`ifdef CMP_FEEDER_TIMEOUT_EN
      wd_q     <= 8'd0;
      tmo_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      wptr_q   <= wptr_d;
      loaded_q <= loaded_d;
      colst_q  <= colst_d;
      topst_q  <= topst_d;
      botst_q  <= botst_d;
      col_q    <= col_d;
      top_q    <= top_d;
      bot_q    <= bot_d;
      bitcol_q <= bitcol_d;
      bittop_q <= bittop_d;
      bitbot_q <= bitbot_d;
      rdyc_q   <= rdyc_d;
      rdyt_q   <= rdyt_d;
      rdyb_q   <= rdyb_d;
      last_q   <= last_d;
      result_q <= result_d;
      rv_q     <= rv_d;
`ifdef CMP_FEEDER_TIMEOUT_EN
      wd_q     <= wd_d;
      tmo_q    <= tmo_d;
`endif
    end
  end

  assign bus.load_ready      = (state_q == IDLE);
  assign bus.busy            = (state_q != IDLE);
  assign bus.cmp_start       = (state_q == START);
  assign bus.bitcolumn       = bitcol_q;
  assign bus.bitrowtop       = bittop_q;
  assign bus.bitrowbot       = bitbot_q;
  assign bus.nextcolumnready = rdyc_q;
  assign bus.nextrowtopready = rdyt_q;
  assign bus.nextrowbotready = rdyb_q;
  assign bus.lastcolumn      = last_q;
  assign bus.result          = result_q;
  assign bus.result_valid    = rv_q;
`ifdef CMP_FEEDER_TIMEOUT_EN
  assign bus.timeout_err     = tmo_q;
`else
  assign bus.timeout_err     = 1'b0;
`endif

endmodule

// File: tb/tb_cmp_feeder.sv
// tb_cmp_feeder -- scoreboard bench for cmp_feeder with a randomized comparator model.
module tb_cmp_feeder;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cmp_feeder_if bus ();
  cmp_feeder u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  // expected responses, pushed when stimulus is issued
  logic [63:0] exp_col [$];
  logic [23:0] exp_top [$];
  logic [23:0] exp_bot [$];
  logic [15:0] exp_res [$];

  // reference bitmap model
  logic [23:0] ref_mem [64];
  int          ref_wptr = 0;
  bit          ref_loaded = 1'b0;
  logic [15:0] cur_res = '0;

  int col_cnt = 0, top_cnt = 0, bot_cnt = 0, cs_cnt = 0, rv_cnt = 0;
  int rv_exp = 0, starts_exp = 0;
  bit model_en = 1'b1;
  bit col_idle;
  bit cs_prev = 1'b0, rv_prev = 1'b0;
  bit col_first = 1'b1, col_lo = 1'b0, col_hi = 1'b0;
  logic [63:0] col8_word = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic void ref_write(input logic [23:0] row);
    ref_mem[ref_wptr] = row;
    if (ref_wptr == 63) ref_loaded = 1'b1;
    ref_wptr = (ref_wptr + 1) % 64;
  endfunction

  function automatic logic [63:0] ref_col(input int c);
    logic [63:0] w;
    for (int r = 0; r < 64; r++) w[r] = ref_mem[r][c];
    return w;
  endfunction

  // Expected slice streams for a feed of the current reference bitmap.
  function automatic void push_feed();
    int ones;
    ones = 0;
    for (int c = 0; c < 24; c++) exp_col.push_back(ref_col(c));
    for (int r = 0; r < 64; r++) begin
      exp_top.push_back(ref_mem[r]);
      exp_bot.push_back(ref_mem[63 - r]);
      ones += $countones(ref_mem[r]);
    end
    cur_res = ones[15:0];
  endfunction

  function automatic void flush();
    exp_col.delete();
    exp_top.delete();
    exp_bot.delete();
  endfunction

  task automatic load(input logic [23:0] row);
    bus.load_valid = 1'b1;
    bus.load_row   = row;
    tick(1);
    bus.load_valid = 1'b0;
    ref_write(row);
  endtask

  task automatic pulse_go(input bit with_load, input logic [23:0] row);
    bus.go = 1'b1;
    if (with_load) begin
      bus.load_valid = 1'b1;
      bus.load_row   = row;
    end
    if (ref_loaded) begin
      push_feed();
      starts_exp++;
    end
    if (with_load) ref_write(row);
    tick(1);
    bus.go = 1'b0;
    bus.load_valid = 1'b0;
  endtask

  // Let the comparator model work until all columns are checked, then report a verdict.
  task automatic run_feed();
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk);
      if (col_cnt == 24 && col_idle && top_cnt >= 11) break;
    end
    check("feed_progress", (col_cnt == 24 && col_idle && top_cnt >= 11), 1);
    #1;
    exp_res.push_back(cur_res);
    rv_exp++;
    bus.cmp_result = cur_res;
    bus.cmp_done   = 1'b1;
    tick(1);
    bus.cmp_done   = 1'b0;
    tick(3);
    check("busy_after_done", bus.busy, 0);
    check("column_pulses", col_cnt, 24);
    check("top_rows_min", top_cnt >= 11, 1);
    check("lastcolumn_held", bus.lastcolumn, 1);
    check("result_reg", bus.result, cur_res);
    check("result_count", rv_cnt, rv_exp);
    check("start_count", cs_cnt, starts_exp);
    flush();
    tick(12);
  endtask

  // Comparator model: per channel, drop the request after a slice then raise it later.
  initial begin
    bus.nextcolumn = 1'b1;
    col_idle = 1'b1;
    forever begin
      @(negedge clk);
      if (model_en && bus.nextcolumnready) begin
        col_idle = 1'b0;
        repeat ($urandom_range(3, 1)) @(posedge clk);
        #1 bus.nextcolumn = 1'b0;
        repeat ($urandom_range(6, 1)) @(posedge clk);
        #1 bus.nextcolumn = 1'b1;
        col_idle = 1'b1;
      end
    end
  end

  initial begin
    bus.nextrowtop = 1'b1;
    forever begin
      @(negedge clk);
      if (model_en && bus.nextrowtopready) begin
        repeat ($urandom_range(2, 1)) @(posedge clk);
        #1 bus.nextrowtop = 1'b0;
        repeat ($urandom_range(3, 1)) @(posedge clk);
        #1 bus.nextrowtop = 1'b1;
      end
    end
  end

  initial begin
    bus.nextrowbot = 1'b1;
    forever begin
      @(negedge clk);
      if (model_en && bus.nextrowbotready) begin
        repeat ($urandom_range(3, 1)) @(posedge clk);
        #1 bus.nextrowbot = 1'b0;
        repeat ($urandom_range(5, 1)) @(posedge clk);
        #1 bus.nextrowbot = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a slice or a result.
  always @(negedge clk) begin
    if (bus.cmp_start) begin
      check("cmp_start_one_cycle", cs_prev, 0);
      cs_cnt++;
      col_cnt = 0;
      top_cnt = 0;
      bot_cnt = 0;
      col_first = 1'b1;
      col_lo = 1'b0;
      col_hi = 1'b0;
    end
    cs_prev = bus.cmp_start;

    if (bus.nextcolumnready) begin
      if (!col_first) check("column_handshake", col_hi, 1);
      col_first = 1'b0;
      col_lo = 1'b0;
      col_hi = 1'b0;
      if (col_cnt == 8) col8_word = bus.bitcolumn;
      if (exp_col.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL bitcolumn_extra: got pulse %0d, expected none", col_cnt);
      end else check("bitcolumn", bus.bitcolumn, exp_col.pop_front());
      check("lastcolumn", bus.lastcolumn, col_cnt == 23);
      col_cnt++;
    end else begin
      if (!bus.nextcolumn) col_lo = 1'b1;
      else if (col_lo) col_hi = 1'b1;
    end

    if (bus.nextrowtopready) begin
      if (exp_top.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL bitrowtop_extra: got pulse %0d, expected none", top_cnt);
      end else check("bitrowtop", bus.bitrowtop, exp_top.pop_front());
      top_cnt++;
    end

    if (bus.nextrowbotready) begin
      if (exp_bot.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL bitrowbot_extra: got pulse %0d, expected none", bot_cnt);
      end else check("bitrowbot", bus.bitrowbot, exp_bot.pop_front());
      bot_cnt++;
    end

    if (bus.result_valid) begin
      check("result_valid_one_cycle", rv_prev, 0);
      if (exp_res.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL result_extra: got result %0h, expected no result", bus.result);
      end else check("result", bus.result, exp_res.pop_front());
      rv_cnt++;
    end
    rv_prev = bus.result_valid;
  end

  initial begin
    #600000;
    $display("FAIL global_timeout: got no completion, expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int low_cnt;
    rst_n = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_row   = '0;
    bus.go         = 1'b0;
    bus.cmp_done   = 1'b0;
    bus.cmp_result = '0;
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // reset state
    check("rst_load_ready", bus.load_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_cmp_start", bus.cmp_start, 0);
    check("rst_colready", bus.nextcolumnready, 0);
    check("rst_topready", bus.nextrowtopready, 0);
    check("rst_botready", bus.nextrowbotready, 0);
    check("rst_bitcolumn", bus.bitcolumn, 0);
    check("rst_bitrowtop", bus.bitrowtop, 0);
    check("rst_bitrowbot", bus.bitrowbot, 0);
    check("rst_lastcolumn", bus.lastcolumn, 0);
    check("rst_result", bus.result, 0);
    check("rst_result_valid", bus.result_valid, 0);
    check("rst_timeout_err", bus.timeout_err, 0);

    // single marked pixel at row 10, column 8; go with only 63 rows is ignored
    for (int r = 0; r < 63; r++) load((r == 10) ? 24'h000100 : 24'h000000);
    pulse_go(1'b0, '0);
    tick(4);
    check("go_63rows_busy", bus.busy, 0);
    check("go_63rows_starts", cs_cnt, starts_exp);
    load(24'h000000);
    pulse_go(1'b0, '0);
    run_feed();
    check("col8_word", col8_word, 64'h400);

    // random bitmap
    for (int r = 0; r < 64; r++) load(24'($urandom));
    pulse_go(1'b0, '0);
    run_feed();

    // partial reload overwrites from row 0, loaded stays set
    for (int r = 0; r < 5; r++) load(24'($urandom));
    pulse_go(1'b0, '0);
    run_feed();

    // asynchronous reset while the column channel is at column 5
    pulse_go(1'b0, '0);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      if (col_cnt >= 6) break;
    end
    check("reached_column5", col_cnt >= 6, 1);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_load_ready", bus.load_ready, 1);
    check("abort_colready", bus.nextcolumnready, 0);
    check("abort_bitcolumn", bus.bitcolumn, 0);
    check("abort_bitrowtop", bus.bitrowtop, 0);
    check("abort_bitrowbot", bus.bitrowbot, 0);
    check("abort_lastcolumn", bus.lastcolumn, 0);
    check("abort_result", bus.result, 0);
    tick(2);
    rst_n = 1'b1;
    ref_wptr = 0;
    ref_loaded = 1'b0;
    flush();
    tick(12);
    check("abort_no_result", rv_cnt, rv_exp);
    pulse_go(1'b0, '0);
    tick(4);
    check("abort_loaded_cleared", bus.busy, 0);
    check("abort_starts", cs_cnt, starts_exp);

    // go together with the 64th write uses the pre-write loaded flag
    for (int r = 0; r < 63; r++) load(24'($urandom));
    pulse_go(1'b1, 24'($urandom));
    tick(4);
    check("go_with_last_write_busy", bus.busy, 0);
    check("go_with_last_write_starts", cs_cnt, starts_exp);
    pulse_go(1'b0, '0);
    run_feed();

    // comparator that never answers
    model_en = 1'b0;
    pulse_go(1'b0, '0);
`ifdef CMP_FEEDER_TIMEOUT_EN
    low_cnt = 0;
    while (!bus.timeout_err && low_cnt < 400) begin
      tick(1);
      low_cnt++;
    end
    check("timeout_err", bus.timeout_err, 1);
    check("timeout_busy", bus.busy, 0);
    check("timeout_latency", low_cnt >= 250, 1);
    tick(4);
    check("timeout_no_result", rv_cnt, rv_exp);
`else
    low_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      tick(1);
      if (!bus.busy) low_cnt++;
    end
    check("stall_busy_held", low_cnt, 0);
    check("stall_timeout_err", bus.timeout_err, 0);
    check("stall_no_result", rv_cnt, rv_exp);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(2);
`endif
    flush();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cmp_feeder.md
CMP_FEEDER -- requirements
Module: cmp_feeder

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-002 SHALL have ports: load_valid  in  1  row write strobe; load_row  in  24  bitmap row data, bit c = column c; load_ready  out  1  high while IDLE.
REQ-003 SHALL have ports: go  in  1  start feed pulse; busy  out  1  high outside IDLE; cmp_start  out  1  comparator reset/start pulse.
REQ-004 SHALL have ports: bitcolumn  out  64; bitrowtop  out  24; bitrowbot  out  24; nextcolumnready, nextrowtopready, nextrowbotready  out  1 each, data-valid pulses; lastcolumn  out  1.
REQ-005 SHALL have ports: nextcolumn, nextrowtop, nextrowbot  in  1 each, comparator "slice checked" levels; cmp_done  in  1; cmp_result  in  16.
REQ-006 SHALL have ports: result  out  16; result_valid  out  1; timeout_err  out  1.

Function
REQ-007 Bitmap SHALL be 64 rows x 24 columns, row 0 = top, held in internal 64x24 storage.
REQ-008 In IDLE, load_valid SHALL write load_row to row wptr, wptr increments mod 64; write of row 63 sets loaded; load_valid ignored outside IDLE.
REQ-009 Top FSM states SHALL be IDLE, START, FEED; go in IDLE with loaded=1 -> START; go otherwise ignored.
REQ-010 START SHALL last one cycle with cmp_start=1, reset channel indices (col=0, top=0, bot=63), clear lastcolumn, then -> FEED.
REQ-011 Three independent channel FSMs (column, top row, bottom row) SHALL each cycle SEND -> WAITLOW -> WAITHIGH, entered at SEND on FEED entry.
REQ-012 SEND: one cycle, load data register, ready pulse=1; column data bitcolumn[r] = row r bit col; bitrowtop = row top; bitrowbot = row bot.
REQ-013 WAITLOW SHALL wait for its request input = 0; WAITHIGH SHALL wait for request = 1, then advance index (col+1, top+1, bot-1) and -> SEND, or -> CDONE if index was final (col 23, top 63, bot 0).
REQ-014 Data registers SHALL hold their value between SEND cycles and after CDONE.
REQ-015 lastcolumn SHALL be 1 from the SEND of column 23 until next START or reset.
REQ-016 In FEED, cmp_done=1 SHALL capture cmp_result into result, pulse result_valid one cycle, and -> IDLE regardless of channel states.
REQ-017 loaded SHALL remain set after a feed so go re-runs same bitmap; new loads overwrite rows from wptr.
REQ-018 Simultaneous go and load_valid in IDLE: write SHALL occur, go evaluated with pre-write loaded.

Reset
REQ-019 rst_n=0 SHALL asynchronously force: IDLE, wptr=0, loaded=0, all ready pulses/cmp_start/result_valid/lastcolumn/timeout_err=0, result=0, data registers=0, busy=0, load_ready=1 after release.
REQ-020 Reset mid-FEED SHALL abort without result_valid; storage contents need not be cleared.

Configuration
REQ-021 Macro CMP_FEEDER_TIMEOUT_EN defined: 8-bit watchdog in FEED, cleared on any ready pulse, counts otherwise; reaching 255 -> timeout_err=1 (sticky until next START), -> IDLE, no result_valid.
REQ-022 Macro undefined: no watchdog, timeout_err tied 0, FEED waits indefinitely for cmp_done.

Verification
REQ-023 Load 64 rows, only row 10 = 24'h000100, go, comparator model -> bitcolumn of col 8 = 64'h400, top sends rows 0..10 at least, lastcolumn set at col 23, result = model value, result_valid one cycle.
REQ-024 go with 63 rows loaded -> no cmp_start, busy stays 0; load row 63 then go -> cmp_start one cycle.
REQ-025 Model holding request low 5 cycles after ready -> no further SEND until request rises; exactly 24 column pulses total.
REQ-026 rst_n asserted mid-FEED at column 5 -> outputs zero immediately, IDLE, loaded=0.
REQ-027 CMP_FEEDER_TIMEOUT_EN, model never raises requests -> timeout_err=1 after 255 idle cycles, busy=0, result_valid never 1; macro off -> busy stays 1.
